bsg_cordic_hyperbolic_vectoring_iter: RTL and testbench

BSG_CORDIC_HYPERBOLIC_VECTORING_ITER -- requirements
Module: bsg_cordic_hyperbolic_vectoring_iter

---
 rtl/bsg_cordic_hyperbolic_vectoring_iter_pkg.sv | 44 ++++
 rtl/bsg_cordic_atanh_rom.sv | 33 +++
 rtl/bsg_cordic_hyperbolic_vectoring_iter.sv | 153 +++++++++++++++
 tb/tb_bsg_cordic_hyperbolic_vectoring_iter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cordic_hyperbolic_vectoring_iter_pkg.sv
// Shared types and constants for the iterative
// hyperbolic-vectoring CORDIC.
package bsg_cordic_hyperbolic_vectoring_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } cordic_state_e;

  // Shift indices executed twice so the hyperbolic
  // iteration converges.
  localparam int rep_idx_a_c = 4;
  localparam int rep_idx_b_c = 13;
  localparam int rep_idx_c_c = 40;

  // Hyperbolic gain An of the full rotation sequence.
  localparam real cordic_an_c = 0.82816;

  // round(atanh(2^-idx) * 2^frac), from the odd power
  // series with wide guard bits so ties round right.
  function automatic longint unsigned atanh_q(
    input int idx,
    input int frac
  );
    logic [191:0] acc;
    logic [191:0] term;
    int g;
    int f;
    g   = 2 * frac + 16;
    f   = frac + g;
    acc = '0;
    for (int k = 0; k < 128; k++) begin
      if (idx * (2 * k + 1) <= f) begin
        term = (192'd1 << (f - idx * (2 * k + 1)))
             / 192'(2 * k + 1);
        acc  = acc + term;
      end
    end
    acc = (acc + (192'd1 << (g - 1))) >> g;
    return acc[63:0];
  endfunction

endpackage

// File: rtl/bsg_cordic_atanh_rom.sv
// Combinational atanh(2^-i) table in the z fixed-point
// format; entries are elaboration-time constants.
module bsg_cordic_atanh_rom
  import bsg_cordic_hyperbolic_vectoring_iter_pkg::*;
#(
  parameter int ang_width_p = 16,
  parameter int frac_p      = 12,
  parameter int iter_p      = 16,
  parameter int idx_width_p = $clog2(iter_p + 2)
) (
  input  logic [idx_width_p-1:0] idx_i,
  output logic [ang_width_p-1:0] atanh_o
);

  logic [ang_width_p-1:0] lut [0:iter_p];

  assign lut[0] = '0;

  for (genvar g = 1; g <= iter_p; g++) begin : g_lut
    localparam logic [ang_width_p-1:0] val_lp =
      ang_width_p'(atanh_q(g, frac_p));
    assign lut[g] = val_lp;
  end

  // Index lookup; out-of-range indices read zero.
  always_comb begin
    atanh_o = '0;
    if (int'(idx_i) <= iter_p) begin
      atanh_o = lut[idx_i];
    end
  end

endmodule

// File: rtl/bsg_cordic_hyperbolic_vectoring_iter.sv
// Iterative hyperbolic-vectoring CORDIC: one micro-
// rotation per cycle, valid/ready in, valid/yumi out.
module bsg_cordic_hyperbolic_vectoring_iter
  import bsg_cordic_hyperbolic_vectoring_iter_pkg::*;
#(
  parameter int ans_width_p = 16,
  parameter int ang_width_p = 16,
  parameter int frac_p      = 12,
  parameter int iter_p      = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  logic signed [ans_width_p-1:0] x_i,
  input  logic signed [ans_width_p-1:0] y_i,
  input  logic signed [ang_width_p-1:0] z_i,
  output logic                          v_o,
  input  logic                          yumi_i,
  output logic signed [ans_width_p-1:0] x_o,
  output logic signed [ans_width_p-1:0] y_o,
  output logic signed [ang_width_p-1:0] z_o
);

  localparam int idx_width_lp = $clog2(iter_p + 2);

  cordic_state_e state_r, state_n;

  logic [idx_width_lp-1:0] idx_r;
  logic                    rep_done_r;

  logic signed [ans_width_p-1:0] x_r, y_r;
  logic signed [ans_width_p-1:0] x_n, y_n;
  logic signed [ans_width_p-1:0] x_sh, y_sh;
  logic signed [ang_width_p-1:0] z_r, z_n;
  logic        [ang_width_p-1:0] atanh_w;

  logic load;
  logic step;
  logic is_rep;
  logic at_last;
  logic d_pos;

  bsg_cordic_atanh_rom #(
    .ang_width_p (ang_width_p),
    .frac_p      (frac_p),
    .iter_p      (iter_p),
    .idx_width_p (idx_width_lp)
  ) rom (
    .idx_i   (idx_r),
    .atanh_o (atanh_w)
  );

  // Flag shift indices that run twice.
  always_comb begin
    is_rep = 1'b0;
    unique case (1'b1)
      (int'(idx_r) == rep_idx_a_c): is_rep = 1'b1;
      (int'(idx_r) == rep_idx_b_c): is_rep = 1'b1;
      (int'(idx_r) == rep_idx_c_c): is_rep = 1'b1;
      default:                      is_rep = 1'b0;
    endcase
  end

  assign at_last = (int'(idx_r) == iter_p)
                 && (!is_rep || rep_done_r);

  // Next state and datapath enables.
  always_comb begin
    state_n = state_r;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (v_i) begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (at_last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (yumi_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // One micro-rotation: d=+1 when y is negative.
  always_comb begin
    d_pos = y_r[ans_width_p-1];
    x_sh  = x_r >>> idx_r;
    y_sh  = y_r >>> idx_r;
    if (d_pos) begin
      x_n = x_r + y_sh;
      y_n = y_r + x_sh;
      z_n = z_r - atanh_w;
    end else begin
      x_n = x_r - y_sh;
      y_n = y_r - x_sh;
      z_n = z_r + atanh_w;
    end
  end

  // Operand capture, rotation and shift sequencing.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= '0;
      idx_r      <= '0;
      rep_done_r <= 1'b0;
    end else if (load) begin
      x_r        <= x_i;
      y_r        <= y_i;
      z_r        <= z_i;
      idx_r      <= idx_width_lp'(1);
      rep_done_r <= 1'b0;
    end else if (step) begin
      x_r <= x_n;
      y_r <= y_n;
      z_r <= z_n;
      if (is_rep && !rep_done_r) begin
        rep_done_r <= 1'b1;
      end else begin
        rep_done_r <= 1'b0;
        idx_r      <= idx_r + idx_width_lp'(1);
      end
    end
  end

  assign ready_o = (state_r == IDLE);
  assign v_o     = (state_r == DONE);
  assign x_o     = x_r;
  assign y_o     = y_r;
  assign z_o     = z_r;

endmodule

// File: tb/tb_bsg_cordic_hyperbolic_vectoring_iter.sv
// Bench for the iterative hyperbolic-vectoring CORDIC.
// Directed table, random ops, stall and reset cases.
module tb_bsg_cordic_hyperbolic_vectoring_iter;
  import bsg_cordic_hyperbolic_vectoring_iter_pkg::*;

  localparam int W    = 16;
  localparam int AW   = 16;
  localparam int FRAC = 12;
  localparam int ITER = 16;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b0;
  logic v_i       = 1'b0;
  logic yumi_i    = 1'b0;
  logic ready_o;
  logic v_o;
  logic signed [W-1:0]  x_i = '0;
  logic signed [W-1:0]  y_i = '0;
  logic signed [AW-1:0] z_i = '0;
  logic signed [W-1:0]  x_o;
  logic signed [W-1:0]  y_o;
  logic signed [AW-1:0] z_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  bsg_cordic_hyperbolic_vectoring_iter #(
    .ans_width_p (W),
    .ang_width_p (AW),
    .frac_p      (FRAC),
    .iter_p      (ITER)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .x_i       (x_i),
    .y_i       (y_i),
    .z_i       (z_i),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .x_o       (x_o),
    .y_o       (y_o),
    .z_o       (z_o)
  );

  typedef struct {
    int x;
    int y;
    int z;
    int ex;
    int ey;
    int ez;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name,
                         input longint act,
                         input longint exp,
                         input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d want %0d +/-%0d",
               name, act, exp, tol);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  // Exact atanh(2^-s) in the z format.
  function automatic int atanh_ref(input int s);
    real t;
    real a;
    t = 1.0 / real'(longint'(1) << s);
    a = 0.5 * $ln((1.0 + t) / (1.0 - t));
    return $rtoi(a * real'(1 << FRAC) + 0.5);
  endfunction

  // Shift schedule then plain-integer rotations.
  function automatic void model(
    input  int x0, input int y0, input int z0,
    output int xo, output int yo, output int zo,
    output int n
  );
    int sched[$];
    int x, y, z;
    x = wrap16(x0);
    y = wrap16(y0);
    z = wrap16(z0);
    for (int s = 1; s <= ITER; s++) begin
      sched.push_back(s);
      if (s == 4 || s == 13 || s == 40)
        sched.push_back(s);
    end
    n = sched.size();
    foreach (sched[k]) begin
      int s, a, xs, ys, nx, ny, nz;
      s  = sched[k];
      a  = atanh_ref(s);
      xs = x >>> s;
      ys = y >>> s;
      if (y < 0) begin
        nx = x + ys;
        ny = y + xs;
        nz = z - a;
      end else begin
        nx = x - ys;
        ny = y - xs;
        nz = z + a;
      end
      x = wrap16(nx);
      y = wrap16(ny);
      z = wrap16(nz);
    end
    xo = x;
    yo = y;
    zo = z;
  endfunction

  task automatic accept(input int x,
                        input int y,
                        input int z);
    int w;
    w = 0;
    while (!ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    chk("ready_before_accept", ready_o, 1);
    x_i = 16'(x);
    y_i = 16'(y);
    z_i = 16'(z);
    v_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!v_o && lat < 100) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
  endtask

  task automatic chk_model(input int x,
                           input int y,
                           input int z,
                           input int lat);
    int mx, my, mz, n;
    model(x, y, z, mx, my, mz, n);
    chk("latency", lat, n);
    chk("x_model", x_o, mx);
    chk("y_model", y_o, my);
    chk("z_model", z_o, mz);
  endtask

  task automatic pop();
    yumi_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    yumi_i = 1'b0;
    chk("ready_after_yumi", ready_o, 1);
    chk("v_o_after_yumi", v_o, 0);
  endtask

  initial begin
    int lat;
    int x, y, z, m;
    int sx, sy, sz;
    int hi;

    vecs[0] = '{4096,  2048,    0, 2938, 0,  2250};
    vecs[1] = '{4096, -2048, 1000, 2938, 0, -1250};
    vecs[2] = '{4096,     0,  500, 3392, 0,   500};

    #1;
    chk("rst_v_o", v_o, 0);
    chk("rst_x_o", x_o, 0);
    chk("rst_y_o", y_o, 0);
    chk("rst_z_o", z_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1);

    foreach (vecs[i]) begin
      accept(vecs[i].x, vecs[i].y, vecs[i].z);
      wait_done(lat);
      chk("vec_latency", lat, 18);
      chk_tol("vec_x", x_o, vecs[i].ex, 4);
      chk_tol("vec_y", y_o, vecs[i].ey, 4);
      chk_tol("vec_z", z_o, vecs[i].ez, 4);
      chk_model(vecs[i].x, vecs[i].y,
                vecs[i].z, lat);
      pop();
    end

    accept(-4096, 8000, 0);
    wait_done(lat);
    chk("ood_latency", lat, 18);
    chk("ood_no_x",
        32'($isunknown({x_o, y_o, z_o})), 0);
    chk_model(-4096, 8000, 0, lat);
    pop();

    for (int r = 0; r < 24; r++) begin
      if (r % 2 == 0) begin
        x = int'($urandom_range(1000, 7000));
        m = (x * 3) / 4;
        y = int'($urandom_range(0, 2 * m)) - m;
        z = int'($urandom_range(0, 2000)) - 1000;
      end else begin
        x = int'($urandom_range(0, 65535)) - 32768;
        y = int'($urandom_range(0, 65535)) - 32768;
        z = int'($urandom_range(0, 65535)) - 32768;
      end
      accept(x, y, z);
      wait_done(lat);
      chk_model(x, y, z, lat);
      pop();
    end

    accept(3000, 1000, 100);
    wait_done(lat);
    chk_model(3000, 1000, 100, lat);
    sx = x_o;
    sy = y_o;
    sz = z_o;
    v_i = 1'b1;
    x_i = 16'sd123;
    y_i = 16'sd45;
    z_i = 16'sd6;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("stall_v_o", v_o, 1);
      chk("stall_ready", ready_o, 0);
      chk("stall_x", x_o, sx);
      chk("stall_y", y_o, sy);
      chk("stall_z", z_o, sz);
    end
    v_i = 1'b0;
    pop();
    accept(5000, -1500, -300);
    wait_done(lat);
    chk_model(5000, -1500, -300, lat);
    pop();

    accept(4096, 1024, 0);
    repeat (7) @(posedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("abort_v_o", v_o, 0);
    chk("abort_x", x_o, 0);
    chk("abort_y", y_o, 0);
    chk("abort_z", z_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    hi = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (v_o) hi++;
    end
    chk("abort_no_v_o", hi, 0);
    accept(4096, 1024, 0);
    wait_done(lat);
    chk_model(4096, 1024, 0, lat);
    pop();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
